// File: rtl/sram_frame_reader.sv
// sram_frame_reader: reads 16-bit words from the shared SRAM FIFO using the
// read/hint handshake. It checks the two-word header {CMD_TX, len+2} then
// {0x00, len} and unpacks the payload high byte first into a byte stream.
// Optional build macro FRAME_LEN_PREFIX_EN: frame_len is sent as an extra
// leading byte that carries tx_sof.
module sram_frame_reader #(
    parameter logic [7:0]  CMD_TX       = 8'h66,
    parameter int unsigned MAX_LEN      = 64,
    parameter int unsigned HINT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sram_read,
    input  logic        sram_hint,
    input  logic [15:0] data_from_sram,
    input  logic        sram_empty,
    input  logic [10:0] sram_count,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [7:0]  frame_len,
    output logic        busy,
    output logic        frame_done,
    output logic        hdr_err
);

    typedef enum logic [2:0] {
        IDLE, RD_H0, RD_H1, RD_D, EMIT_HI, EMIT_LO, DONE, EMIT_PFX
    } state_t;

    localparam int unsigned   TW      = $clog2(HINT_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(HINT_TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [7:0]    len_l2;
    logic [7:0]    bytes_sent;
    logic [7:0]    lo_hold;

    logic       word_avail;
    logic       rd_state;
    logic       word_ok;
    logic       accept;
    logic [7:0] w_hi;
    logic [7:0] w_lo;
    logic [7:0] sent_p1;
    logic [7:0] sent_p2;

    // The FIFO is treated as holding data only when flag and count agree.
    assign word_avail = !sram_empty && (sram_count != '0);
    assign rd_state   = (state == RD_H0) || (state == RD_H1) || (state == RD_D);
    assign word_ok    = rd_state && sram_read && sram_hint;
    assign accept     = tx_valid && tx_ready;
    assign w_hi       = data_from_sram[15:8];
    assign w_lo       = data_from_sram[7:0];
    assign sent_p1    = bytes_sent + 8'd1;
    assign sent_p2    = bytes_sent + 8'd2;
    assign busy       = (state != IDLE);

    // Frame FSM: read handshake, header checks and byte emission.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_read  <= 1'b0;
            to_cnt     <= '0;
            len_l2     <= '0;
            bytes_sent <= '0;
            lo_hold    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;

            // Shared request/hint handshake for every word-read state.
            // Requests are only issued from a cycle with sram_read low.
            if (rd_state) begin
                if (!sram_read) begin
                    if (word_avail) begin
                        sram_read <= 1'b1;
                        to_cnt    <= '0;
                    end
                end else if (sram_hint) begin
                    sram_read <= 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    sram_read <= 1'b0;
                    hdr_err   <= 1'b1;
                    state     <= IDLE;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (word_avail) state <= RD_H0;
                end
                RD_H0: begin
                    if (word_ok) begin
                        if (w_hi != CMD_TX) begin
                            hdr_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            len_l2 <= w_lo;
                            state  <= RD_H1;
                        end
                    end
                end
                RD_H1: begin
                    if (word_ok) begin
                        if ((w_hi != 8'h00) || (len_l2 != w_lo + 8'd2) ||
                            (32'(w_lo) > MAX_LEN)) begin
                            hdr_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_len  <= w_lo;
                            bytes_sent <= '0;
`ifdef FRAME_LEN_PREFIX_EN
                            tx_data  <= w_lo;
                            tx_valid <= 1'b1;
                            tx_sof   <= 1'b1;
                            tx_eof   <= (w_lo == 8'd0);
                            state    <= EMIT_PFX;
`else
                            if (w_lo == 8'd0) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= RD_D;
                            end
`endif
                        end
                    end
                end
                RD_D: begin
                    if (word_ok) begin
                        lo_hold  <= w_lo;
                        tx_data  <= w_hi;
                        tx_valid <= 1'b1;
`ifdef FRAME_LEN_PREFIX_EN
                        tx_sof   <= 1'b0;
`else
                        tx_sof   <= (bytes_sent == 8'd0);
`endif
                        tx_eof   <= (sent_p1 == frame_len);
                        state    <= EMIT_HI;
                    end
                end
                EMIT_PFX: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        tx_sof   <= 1'b0;
                        tx_eof   <= 1'b0;
                        state    <= (frame_len == 8'd0) ? DONE : RD_D;
                    end
                end
                EMIT_HI: begin
                    if (accept) begin
                        bytes_sent <= sent_p1;
                        tx_sof     <= 1'b0;
                        // Odd length ends here; the padding byte is dropped.
                        if (sent_p1 == frame_len) begin
                            tx_valid <= 1'b0;
                            tx_eof   <= 1'b0;
                            state    <= DONE;
                        end else begin
                            tx_data <= lo_hold;
                            tx_eof  <= (sent_p2 == frame_len);
                            state   <= EMIT_LO;
                        end
                    end
                end
                EMIT_LO: begin
                    if (accept) begin
                        bytes_sent <= sent_p1;
                        tx_valid   <= 1'b0;
                        tx_eof     <= 1'b0;
                        state      <= (sent_p1 == frame_len) ? DONE : RD_D;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_frame_reader.sv
// Randomized bench for sram_frame_reader with a word-list frame parser model.
`timescale 1ns/1ps
module tb_sram_frame_reader;

    localparam int unsigned TO = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_read;
    logic        sram_hint = 1'b0;
    logic [15:0] data_from_sram = '0;
    logic        sram_empty = 1'b1;
    logic [10:0] sram_count = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_sof;
    logic        tx_eof;
    logic [7:0]  frame_len;
    logic        busy;
    logic        frame_done;
    logic        hdr_err;

    always #5 clk = ~clk;

    sram_frame_reader #(
        .CMD_TX(8'h66),
        .MAX_LEN(64),
        .HINT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .sram_read(sram_read), .sram_hint(sram_hint),
        .data_from_sram(data_from_sram), .sram_empty(sram_empty),
        .sram_count(sram_count),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sof(tx_sof), .tx_eof(tx_eof), .frame_len(frame_len),
        .busy(busy), .frame_done(frame_done), .hdr_err(hdr_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic [7:0] len;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo[$];
    logic [15:0] stim[$];
    logic [7:0]  acc_log[$];

    int checks = 0;
    int errors = 0;
    int err_n = 0, done_n = 0, reads_n = 0;
    int rmode = 1;          // 0 random, 1 always, 2 toggle, 3 never, 4 manual
    bit chk_en = 1'b0;
    bit hint_dis = 1'b0;
    int lat = 0;

    logic       p_valid = 1'b0, p_ready = 1'b0, p_sof = 1'b0, p_eof = 1'b0;
    logic [7:0] p_data = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Reference: parse the word list by the framing rules into expected bytes.
    task automatic model_stim(output int e_err, output int e_done);
        int i, n, lo;
        logic [15:0] w0, w1, wd;
        logic [7:0] b;
        exp_t e;
        i = 0; n = stim.size(); e_err = 0; e_done = 0;
        while (i < n) begin
            w0 = stim[i]; i++;
            if (w0[15:8] != 8'h66) begin e_err++; continue; end
            if (i >= n) break;
            w1 = stim[i]; i++;
            lo = int'(w1[7:0]);
            if (w1[15:8] != 8'h00 || w0[7:0] != 8'(lo + 2) || lo > 64) begin
                e_err++; continue;
            end
`ifdef FRAME_LEN_PREFIX_EN
            e.data = 8'(lo); e.sof = 1'b1; e.eof = (lo == 0); e.len = 8'(lo);
            exp_q.push_back(e);
`endif
            for (int k = 0; k < lo; k++) begin
                wd = stim[i + k / 2];
                b = (k % 2 == 0) ? wd[15:8] : wd[7:0];
`ifdef FRAME_LEN_PREFIX_EN
                e.sof = 1'b0;
`else
                e.sof = (k == 0);
`endif
                e.data = b; e.eof = (k == lo - 1); e.len = 8'(lo);
                exp_q.push_back(e);
            end
            i += (lo + 1) / 2;
            e_done++;
        end
    endtask

    // Observe outputs, model the SRAM FIFO and drive tx_ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (p_valid && p_ready) begin
                acc_log.push_back(p_data);
                if (chk_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %02h, no byte expected", p_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (p_data !== e.data || p_sof !== e.sof || p_eof !== e.eof) begin
                            errors++;
                            $display("FAIL byte: got %02h sof %0b eof %0b expected %02h sof %0b eof %0b",
                                     p_data, p_sof, p_eof, e.data, e.sof, e.eof);
                        end
                        if (e.sof) chk("frame_len", frame_len, e.len);
                    end
                end
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, p_data);
            end
            chk("valid_during_read", tx_valid && sram_read, 0);
            if (hdr_err) err_n++;
            if (frame_done) done_n++;
        end

        if (sram_hint) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            reads_n++;
            sram_hint = 1'b0;
            data_from_sram = 16'($urandom);
        end else if (sram_read && !hint_dis && fifo.size() > 0) begin
            if (lat == 0) begin
                sram_hint = 1'b1;
                data_from_sram = fifo[0];
            end else begin
                lat--;
            end
        end else begin
            lat = $urandom_range(0, 3);
        end
        sram_empty = (fifo.size() == 0);
        sram_count = 11'(fifo.size());

        case (rmode)
            0: tx_ready = 1'($urandom);
            1: tx_ready = 1'b1;
            2: tx_ready = !tx_ready;
            3: tx_ready = 1'b0;
            default: ;
        endcase

        if (rst) begin
            p_valid = 1'b0;
        end else begin
            p_valid = tx_valid;
        end
        p_ready = tx_ready;
        p_data  = tx_data;
        p_sof   = tx_sof;
        p_eof   = tx_eof;
    end

    task automatic run_stim(input int rm, input bit gaps, input string tag);
        int e_err, e_done, nw, cyc;
        exp_q.delete();
        model_stim(e_err, e_done);
        nw = stim.size();
        err_n = 0; done_n = 0; reads_n = 0;
        rmode = rm; chk_en = 1'b1;
        acc_log.delete();
        foreach (stim[k]) begin
            fifo.push_back(stim[k]);
            if (gaps) repeat ($urandom_range(0, 3)) tick;
        end
        cyc = 0;
        while (!(fifo.size() == 0 && exp_q.size() == 0 && !busy && !sram_read) && cyc < 20000) begin
            tick;
            cyc++;
        end
        chk({tag, "_drain_in_time"}, (cyc < 20000), 1);
        repeat (3) tick;
        chk({tag, "_hdr_err_count"}, err_n, e_err);
        chk({tag, "_frame_done_count"}, done_n, e_done);
        chk({tag, "_reads"}, reads_n, nw);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
        stim.delete();
        exp_q.delete();
    endtask

    // Pin the model itself to hand-computed byte lists.
    task automatic pin_model(input logic [7:0] lit[$], input int want_err, input string tag);
        int e_err, e_done;
        exp_q.delete();
        model_stim(e_err, e_done);
        chk({tag, "_pin_len"}, exp_q.size(), lit.size());
        chk({tag, "_pin_err"}, e_err, want_err);
        for (int k = 0; k < lit.size() && k < exp_q.size(); k++) begin
            chk({tag, "_pin_data"}, exp_q[k].data, lit[k]);
            chk({tag, "_pin_sof"}, exp_q[k].sof, (k == 0));
            chk({tag, "_pin_eof"}, exp_q[k].eof, (k == lit.size() - 1));
        end
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] lit[$];
        logic [7:0] hb;
        int cyc, len, kind, lo;

        rst = 1'b1;
        repeat (3) tick;
        chk("rst_sram_read", sram_read, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_sof_eof", {tx_sof, tx_eof}, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frame_done, hdr_err}, 0);
        rst = 1'b0;
        tick;

        // Basic odd-length frame, always ready.
        stim = '{16'h6607, 16'h0005, 16'hA1A2, 16'hA3A4, 16'hA5C3};
`ifdef FRAME_LEN_PREFIX_EN
        lit = '{8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`else
        lit = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`endif
        pin_model(lit, 0, "t1");
        run_stim(1, 1'b0, "t1");
        chk("t1_dut_count", acc_log.size(), lit.size());
        for (int k = 0; k < lit.size() && k < acc_log.size(); k++)
            chk("t1_dut_byte", acc_log[k], lit[k]);

        // Same frame, ready toggling each cycle.
        stim = '{16'h6607, 16'h0005, 16'hA1A2, 16'hA3A4, 16'hA5C3};
        run_stim(2, 1'b0, "t2");
        chk("t2_dut_count", acc_log.size(), lit.size());

        // Resync over a bad word.
        stim = '{16'h5501, 16'h6604, 16'h0002, 16'hBEEF};
`ifdef FRAME_LEN_PREFIX_EN
        lit = '{8'h02, 8'hBE, 8'hEF};
`else
        lit = '{8'hBE, 8'hEF};
`endif
        pin_model(lit, 1, "t3");
        run_stim(0, 1'b0, "t3");

        // Header length mismatch, then over-length.
        stim = '{16'h6608, 16'h0005};
        lit.delete();
        pin_model(lit, 1, "t4a");
        run_stim(1, 1'b0, "t4a");
        stim = '{16'h6643, 16'h0041};
        pin_model(lit, 1, "t4b");
        run_stim(1, 1'b0, "t4b");

        // Prefix-mode example frame.
        stim = '{16'h6605, 16'h0003, 16'h1122, 16'h3344};
`ifdef FRAME_LEN_PREFIX_EN
        lit = '{8'h03, 8'h11, 8'h22, 8'h33};
`else
        lit = '{8'h11, 8'h22, 8'h33};
`endif
        pin_model(lit, 0, "t6");
        run_stim(0, 1'b1, "t6");

        // Hint never arrives.
        chk_en = 1'b0;
        hint_dis = 1'b1;
        fifo.push_back(16'h5501);
        cyc = 0;
        while (!sram_read && cyc < 50) begin tick; cyc++; end
        chk("to_read_raised", sram_read, 1);
        cyc = 0;
        while (!hdr_err && cyc < 2000) begin tick; cyc++; end
        chk("to_latency", cyc, TO);
        chk("to_read_dropped", sram_read, 0);
        rst = 1'b1;
        fifo.delete();
        repeat (2) tick;
        hint_dis = 1'b0;
        rst = 1'b0;
        tick;

        // Reset while the low byte is being offered.
        rmode = 3;
        fifo.push_back(16'h6604);
        fifo.push_back(16'h0002);
        fifo.push_back(16'hBEEF);
        cyc = 0;
        while (!tx_valid && cyc < 200) begin tick; cyc++; end
`ifdef FRAME_LEN_PREFIX_EN
        chk("rs_prefix", tx_data, 8'h02);
        rmode = 4; tx_ready = 1'b1; tick; tx_ready = 1'b0;
        cyc = 0;
        while (!tx_valid && cyc < 200) begin tick; cyc++; end
`endif
        chk("rs_hi_byte", tx_data, 8'hBE);
        rmode = 4; tx_ready = 1'b1; tick; tx_ready = 1'b0;
        chk("rs_lo_valid", tx_valid, 1);
        chk("rs_lo_byte", tx_data, 8'hEF);
        chk("rs_lo_eof", tx_eof, 1);
        rst = 1'b1;
        tick;
        chk("rs_sram_read", sram_read, 0);
        chk("rs_tx_valid", tx_valid, 0);
        chk("rs_tx_data", tx_data, 0);
        chk("rs_sof_eof", {tx_sof, tx_eof}, 0);
        chk("rs_frame_len", frame_len, 0);
        chk("rs_busy", busy, 0);
        rst = 1'b0;
        fifo.delete();
        exp_q.delete();
        rmode = 1;
        tick;

        // Randomized frame mixes.
        for (int r = 0; r < 6; r++) begin
            for (int f = 0; f < 6; f++) begin
                kind = $urandom_range(0, 7);
                if (kind == 0) begin
                    hb = 8'($urandom_range(0, 255));
                    if (hb == 8'h66) hb = 8'h00;
                    stim.push_back({hb, 8'($urandom)});
                end else if (kind == 1) begin
                    lo = $urandom_range(0, 255);
                    stim.push_back({8'h66, 8'(lo + 3)});
                    stim.push_back({8'h00, 8'(lo)});
                end else begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 2))
                            0: len = 0;
                            1: len = 1;
                            default: len = 64;
                        endcase
                    end else begin
                        len = $urandom_range(0, 64);
                    end
                    stim.push_back({8'h66, 8'(len + 2)});
                    stim.push_back({8'h00, 8'(len)});
                    for (int w = 0; w < (len + 1) / 2; w++) stim.push_back(16'($urandom));
                end
            end
            run_stim($urandom_range(0, 2), 1'b1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_frame_reader.md
Name: sram_frame_reader

Overview:
- Downstream consumer of the SPI-slave TX path. It drains 16-bit words from the shared SRAM FIFO using the same read/hint handshake the SPI side uses for writes.
- It validates the two-word frame header {CMD, len+2} then {0x00, len}, and unpacks the payload into a byte stream for the Si4463 wireless TX controller.
- Payload packing is high byte first; an odd final byte is padded with 0x00.

Parameters:
- CMD_TX, 8'h66, required high byte of header word 0.
- MAX_LEN, 64, largest accepted payload length in bytes (Si4463 TX FIFO depth).
- HINT_TIMEOUT, 1023, clock cycles to wait for sram_hint before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sram_read  out  1  read request; held high until sram_hint is sampled
- sram_hint  in  1  SRAM access done; data_from_sram is valid in the same cycle
- data_from_sram  in  16  word read from the FIFO
- sram_empty  in  1  FIFO empty
- sram_count  in  11  words currently in the FIFO
- tx_data  out  8  payload byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  consumer accepts the byte when tx_valid && tx_ready
- tx_sof  out  1  high together with the first byte of a frame
- tx_eof  out  1  high together with the last byte of a frame
- frame_len  out  8  length of the current frame, latched from header word 1
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- hdr_err  out  1  one-cycle pulse on a header error or timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal byte and word counters 0.
- Read handshake (every FIFO word):
  - Raise sram_read only when !sram_empty.
  - Hold sram_read until the first cycle sram_hint=1. In that cycle, latch data_from_sram.
  - Drop sram_read on the next edge. A new request needs at least one cycle with sram_read=0.
  - Timeout counter starts when sram_read rises. If it reaches HINT_TIMEOUT: sram_read=0, hdr_err pulse, go to IDLE.
- FSM states:
  - IDLE: busy=0. If !sram_empty, go to RD_H0.
  - RD_H0: read word 0.
    - If hi byte != CMD_TX: hdr_err pulse, word discarded, back to IDLE. This resyncs one word per attempt.
    - Otherwise latch lo byte as L2, go to RD_H1.
  - RD_H1: read word 1.
    - Error if hi byte != 0x00, or L2 != (lo+2) mod 256, or lo > MAX_LEN: hdr_err pulse, go to IDLE.
    - Otherwise frame_len=lo.
    - If lo=0: frame_done pulse, go to IDLE. No bytes are emitted.
    - Otherwise go to RD_D.
  - RD_D: read the next payload word into a holding register, go to EMIT_HI.
  - EMIT_HI: drive tx_data = word[15:8] with tx_valid=1.
    - On acceptance, bytes_sent increments.
    - If bytes_sent == frame_len, go to DONE. This covers an odd length: the low byte is dropped and not checked.
    - Otherwise go to EMIT_LO.
  - EMIT_LO: drive word[7:0] the same way.
    - On acceptance: if bytes_sent == frame_len, go to DONE; else go to RD_D.
  - DONE: frame_done pulse for one cycle, go to IDLE.
- Streaming rules:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid never drops before acceptance.
  - tx_valid is 0 while a word read is in flight; bubbles between words are allowed.
- tx_sof/tx_eof: asserted with the first/last byte, qualified by tx_valid. For frame_len=1 both are high on the single byte.
- Read gating: if sram_empty mid-frame, the FSM waits in RD_D with sram_read=0 indefinitely. No timeout applies until a request is issued.
- Event priority: rst has priority over everything. Reset mid-frame drops sram_read and tx_valid on the next edge and abandons the frame; the remainder is resynced via hdr_err.
- Width rules:
  - bytes_sent is 8 bits.
  - The L2 check uses 8-bit wraparound.
  - Words read per frame = 2 + ceil(frame_len/2).

Optional Feature:
- Macro: FRAME_LEN_PREFIX_EN.
- Defined: after header validation, frame_len is emitted as an extra first byte (tx_sof on it) before the payload, for Si4463 variable-length field mode. The bytes_sent/tx_eof logic counts payload bytes only. frame_len=0 emits the single prefix byte with tx_sof=tx_eof=1, then frame_done.
- Undefined: payload bytes only, as described in Behaviour.

Test Plan:
- FIFO words 0x6607, 0x0005, 0xA1A2, 0xA3A4, 0xA5xx, tx_ready=1 -> bytes A1 A2 A3 A4 A5; sof on A1, eof on A5; frame_done once; 5 reads total.
- Same frame with tx_ready toggled 1/0 every cycle -> identical byte sequence; tx_data held stable while stalled; no byte duplicated or lost.
- Words 0x5501, then 0x6604, 0x0002, 0xBEEF -> one hdr_err; then bytes BE EF, eof on EF.
- Words 0x6608, 0x0005 -> hdr_err (length mismatch), FSM back in IDLE. Separately, len=65 with MAX_LEN=64 -> hdr_err.
- sram_hint never asserted after sram_read -> hdr_err exactly HINT_TIMEOUT cycles after sram_read rises; sram_read=0 afterwards. Separately, rst asserted during EMIT_LO -> all outputs 0 on the next edge.
- FRAME_LEN_PREFIX_EN defined with words 0x6605, 0x0003, 0x1122, 0x33xx -> bytes 03 11 22 33; sof on 03, eof on 33.
